spi_dma: RTL and testbench

Byte-stream sequencer that sits directly upstream of the spi controller and drives its 8-bit register interface in place of the CPU.
- Fetches TX bytes from memory and issues start/next-byte writes to the controller.
- Waits on the controller's interrupt, reads back RX bytes and stores them to memory.
- Closes the transaction (CS high) after the last byte.
- Lets the CPU run 1..256-byte SPI transfers (flash/SD reads and writes) with a single command.

---
 rtl/spi_dma_pkg.sv | 35 +++
 rtl/spi_dma_regs.sv | 110 +++++++++++
 rtl/spi_dma.sv | 189 ++++++++++++++++++
 tb/tb_spi_dma.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dma_pkg.sv
// Shared types and constants for the SPI byte-stream sequencer.
package spi_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StGuard,
    StWait,
    StRead,
    StStore,
    StDone
  } state_e;

  // Host register indices
  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegLen    = 3'd1;
  localparam logic [2:0] RegTxLo   = 3'd2;
  localparam logic [2:0] RegTxHi   = 3'd3;
  localparam logic [2:0] RegRxLo   = 3'd4;
  localparam logic [2:0] RegRxHi   = 3'd5;
  localparam logic [2:0] RegStatus = 3'd6;

  // Controller register addresses: START opens/closes a transaction, NEXT continues it
  localparam logic [2:0] SpiStart = 3'd0;
  localparam logic [2:0] SpiNext  = 3'd1;

  // CTRL bit positions
  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlAbort = 1;
  localparam int unsigned CtrlSelLo = 2;
  localparam int unsigned CtrlTxEn  = 4;
  localparam int unsigned CtrlRxEn  = 5;

endpackage

// File: rtl/spi_dma_regs.sv
// Host register file: configuration, STATUS with read-to-clear, and the irq line.
module spi_dma_regs
  import spi_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [2:0]        host_addr_i,
  input  logic [7:0]        host_wdata_i,
  input  logic              host_write_i,
  input  logic              host_read_i,
  output logic [7:0]        host_rdata_o,
  input  logic              busy_i,
  input  logic              done_set_i,
  input  logic              aborted_set_i,
  output logic              start_o,
  output logic              abort_o,
  output logic [7:0]        len_o,
  output logic [ADDR_W-1:0] tx_base_o,
  output logic [ADDR_W-1:0] rx_base_o,
  output logic [1:0]        sel_o,
  output logic              tx_en_o,
  output logic              rx_en_o,
  output logic              irq_o
);

  logic [7:0]  len_q;
  logic [15:0] tx_base_q, rx_base_q;
  logic [1:0]  sel_q;
  logic        tx_en_q, rx_en_q;
  logic        done_q, aborted_q, irq_q;
  logic        ctrl_wr, cfg_we, status_rd;

  assign ctrl_wr   = host_write_i && (host_addr_i == RegCtrl);
  // Configuration is frozen while a transfer is running
  assign cfg_we    = host_write_i && !busy_i;
  assign status_rd = host_read_i && (host_addr_i == RegStatus);
  assign start_o   = ctrl_wr && host_wdata_i[CtrlStart] && !busy_i;
  assign abort_o   = ctrl_wr && host_wdata_i[CtrlAbort] && busy_i;

  assign len_o     = len_q;
  assign tx_base_o = tx_base_q[ADDR_W-1:0];
  assign rx_base_o = rx_base_q[ADDR_W-1:0];
  assign sel_o     = sel_q;
  assign tx_en_o   = tx_en_q;
  assign rx_en_o   = rx_en_q;
  assign irq_o     = irq_q;

  // Configuration registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      len_q     <= 8'h00;
      tx_base_q <= 16'h0000;
      rx_base_q <= 16'h0000;
      sel_q     <= 2'b00;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
    end else if (cfg_we) begin
      case (host_addr_i)
        RegCtrl: begin
          sel_q   <= host_wdata_i[CtrlSelLo +: 2];
          tx_en_q <= host_wdata_i[CtrlTxEn];
          rx_en_q <= host_wdata_i[CtrlRxEn];
        end
        RegLen:  len_q            <= host_wdata_i;
        RegTxLo: tx_base_q[7:0]   <= host_wdata_i;
        RegTxHi: tx_base_q[15:8]  <= host_wdata_i;
        RegRxLo: rx_base_q[7:0]   <= host_wdata_i;
        RegRxHi: rx_base_q[15:8]  <= host_wdata_i;
        default: ;
      endcase
    end
  end

  // Status flags; a completion in the same cycle as a STATUS read is not lost
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      irq_q     <= 1'b0;
    end else if (done_set_i) begin
      done_q    <= 1'b1;
      aborted_q <= aborted_set_i;
      irq_q     <= 1'b1;
    end else begin
      if (status_rd || start_o) done_q <= 1'b0;
      if (status_rd) begin
        aborted_q <= 1'b0;
        irq_q     <= 1'b0;
      end
    end
  end

  // Read mux, combinational on the address
  always_comb begin
    host_rdata_o = 8'h00;
    case (host_addr_i)
      RegCtrl:   host_rdata_o = {2'b00, rx_en_q, tx_en_q, sel_q, 2'b00};
      RegLen:    host_rdata_o = len_q;
      RegTxLo:   host_rdata_o = tx_base_q[7:0];
      RegTxHi:   host_rdata_o = tx_base_q[15:8];
      RegRxLo:   host_rdata_o = rx_base_q[7:0];
      RegRxHi:   host_rdata_o = rx_base_q[15:8];
      RegStatus: host_rdata_o = {5'b00000, aborted_q, done_q, busy_i};
      default:   host_rdata_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/spi_dma.sv
// Byte-stream sequencer driving the SPI controller register interface from memory buffers.
module spi_dma
  import spi_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter logic [7:0]  FILL   = 8'hff
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [2:0]        host_addr_i,
  input  logic [7:0]        host_wdata_i,
  output logic [7:0]        host_rdata_o,
  input  logic              host_write_i,
  input  logic              host_read_i,
  output logic              irq_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  input  logic              mem_ack_i,
  output logic [2:0]        spi_reg_addr_o,
  output logic [7:0]        spi_reg_data_out_o,
  input  logic [7:0]        spi_reg_data_in_i,
  output logic [1:0]        spi_reg_sel_o,
  output logic              spi_reg_write_o,
  output logic              spi_reg_read_o,
  input  logic              spi_irq_i
);

  state_e            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [ADDR_W-1:0] txp_q, txp_d, rxp_q, rxp_d;
  logic [7:0]        byte_q, byte_d;
  logic              first_q, first_d;
  logic              close_q, close_d;
  logic              abort_pend_q, abort_pend_d;

  logic              busy, done_set, start, abort, last;
  logic [7:0]        len;
  logic [ADDR_W-1:0] tx_base, rx_base;
  logic [1:0]        sel;
  logic              tx_en, rx_en;

  assign busy = (state_q != StIdle);

  spi_dma_regs #(
    .ADDR_W (ADDR_W)
  ) u_regs (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .host_addr_i   (host_addr_i),
    .host_wdata_i  (host_wdata_i),
    .host_write_i  (host_write_i),
    .host_read_i   (host_read_i),
    .host_rdata_o  (host_rdata_o),
    .busy_i        (busy),
    .done_set_i    (done_set),
    .aborted_set_i (abort_pend_q),
    .start_o       (start),
    .abort_o       (abort),
    .len_o         (len),
    .tx_base_o     (tx_base),
    .rx_base_o     (rx_base),
    .sel_o         (sel),
    .tx_en_o       (tx_en),
    .rx_en_o       (rx_en),
    .irq_o         (irq_o)
  );

  // Sel is frozen while busy, so it can drive the controller directly
  assign spi_reg_sel_o      = sel;
  assign spi_reg_data_out_o = byte_q;
  // A pending abort closes the transaction at the next readback
  assign last               = (count_q == 8'd1) || abort_pend_q;

  // Sequencer state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      count_q      <= 8'h00;
      txp_q        <= '0;
      rxp_q        <= '0;
      byte_q       <= 8'h00;
      first_q      <= 1'b0;
      close_q      <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      txp_q        <= txp_d;
      rxp_q        <= rxp_d;
      byte_q       <= byte_d;
      first_q      <= first_d;
      close_q      <= close_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Next-state and strobe generation; only one strobe can be active per state
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    txp_d           = txp_q;
    rxp_d           = rxp_q;
    byte_d          = byte_q;
    first_d         = first_q;
    close_d         = close_q;
    abort_pend_d    = abort_pend_q;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = txp_q;
    mem_wdata_o     = byte_q;
    spi_reg_write_o = 1'b0;
    spi_reg_read_o  = 1'b0;
    spi_reg_addr_o  = SpiStart;
    done_set        = 1'b0;

    if (abort && (state_q != StDone)) abort_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d      = len;
          txp_d        = tx_base;
          rxp_d        = rx_base;
          first_d      = 1'b1;
          close_d      = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        if (tx_en) begin
          mem_req_o  = 1'b1;
          mem_addr_o = txp_q;
          if (mem_ack_i) begin
            byte_d  = mem_rdata_i;
            txp_d   = txp_q + 1'b1;
            state_d = StSend;
          end
        end else begin
          byte_d  = FILL;
          state_d = StSend;
        end
      end
      StSend: begin
        spi_reg_write_o = 1'b1;
        spi_reg_addr_o  = first_q ? SpiStart : SpiNext;
        first_d         = 1'b0;
        state_d         = StGuard;
      end
      // Gives the controller a cycle to drop its registered interrupt
      StGuard: state_d = StWait;
      StWait: begin
        if (spi_irq_i) state_d = StRead;
      end
      StRead: begin
        spi_reg_read_o = 1'b1;
        spi_reg_addr_o = last ? SpiStart : SpiNext;
        byte_d         = spi_reg_data_in_i;
        close_d        = last;
        state_d        = StStore;
      end
      StStore: begin
        if (rx_en) begin
          mem_req_o  = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = rxp_q;
          if (mem_ack_i) begin
            rxp_d   = rxp_q + 1'b1;
            count_d = count_q - 8'd1;
            state_d = close_q ? StDone : StFetch;
          end
        end else begin
          count_d = count_q - 8'd1;
          state_d = close_q ? StDone : StFetch;
        end
      end
      StDone: begin
        done_set     = 1'b1;
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_spi_dma.sv
// Directed scoreboard bench for spi_dma with memory and SPI controller models.
module tb_spi_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        host_write, host_read, irq;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [2:0]  spi_reg_addr;
  logic [7:0]  spi_reg_data_out, spi_reg_data_in;
  logic [1:0]  spi_reg_sel;
  logic        spi_reg_write, spi_reg_read, spi_irq;

  always #5 clk = ~clk;

  spi_dma #(
    .ADDR_W (16),
    .FILL   (8'hff)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .host_addr_i        (host_addr),
    .host_wdata_i       (host_wdata),
    .host_rdata_o       (host_rdata),
    .host_write_i       (host_write),
    .host_read_i        (host_read),
    .irq_o              (irq),
    .mem_addr_o         (mem_addr),
    .mem_wdata_o        (mem_wdata),
    .mem_rdata_i        (mem_rdata),
    .mem_req_o          (mem_req),
    .mem_we_o           (mem_we),
    .mem_ack_i          (mem_ack),
    .spi_reg_addr_o     (spi_reg_addr),
    .spi_reg_data_out_o (spi_reg_data_out),
    .spi_reg_data_in_i  (spi_reg_data_in),
    .spi_reg_sel_o      (spi_reg_sel),
    .spi_reg_write_o    (spi_reg_write),
    .spi_reg_read_o     (spi_reg_read),
    .spi_irq_i          (spi_irq)
  );

  int          n_tests, n_fail;
  int          mem_delay, irq_delay;
  logic [7:0]  rx_base;
  logic        idx_clr;

  // Memory contents are a fixed function of the address
  function automatic logic [7:0] tx_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA4;
  endfunction

  // Memory model: acks after mem_delay extra cycles
  int mcnt;
  always @(posedge clk) begin
    if (reset) begin
      mem_ack <= 1'b0;
      mcnt    <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      mcnt    <= 0;
    end else if (mem_req) begin
      if (mcnt >= mem_delay) begin
        mem_ack   <= 1'b1;
        mem_rdata <= tx_byte(mem_addr);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  // SPI controller model: irq drops on a write, rises irq_delay cycles later
  int   scnt;
  logic spend;
  always @(posedge clk) begin
    if (reset) begin
      spi_irq <= 1'b0;
      spend   <= 1'b0;
      scnt    <= 0;
    end else if (spi_reg_write) begin
      spi_irq <= 1'b0;
      spend   <= 1'b1;
      scnt    <= 0;
    end else if (spend) begin
      if (scnt >= irq_delay) begin
        spi_irq <= 1'b1;
        spend   <= 1'b0;
      end else begin
        scnt <= scnt + 1;
      end
    end
  end

  logic [7:0] rd_idx;
  always @(posedge clk) begin
    if (idx_clr) rd_idx <= 8'd0;
    else if (spi_reg_read) rd_idx <= rd_idx + 8'd1;
  end
  assign spi_reg_data_in = rx_base + rd_idx;

  // Bus monitor: one event per cycle, plus strobe-overlap and request-stability counters
  logic [31:0] mon_ev;
  logic        mon_has;
  always_comb begin
    mon_ev  = 32'd0;
    mon_has = 1'b0;
    if (spi_reg_write) begin
      mon_has = 1'b1;
      mon_ev  = {4'd1, 2'b00, spi_reg_sel, 13'd0, spi_reg_addr, spi_reg_data_out};
    end else if (spi_reg_read) begin
      mon_has = 1'b1;
      mon_ev  = {4'd2, 4'd0, 13'd0, spi_reg_addr, 8'd0};
    end else if (mem_req && mem_ack) begin
      mon_has = 1'b1;
      mon_ev  = mem_we ? {4'd4, 4'd0, mem_addr, mem_wdata} : {4'd3, 4'd0, mem_addr, 8'd0};
    end
  end

  logic [31:0] obs_mem [4096];
  int          obs_wr = 0;
  int          ovl_cnt = 0;
  int          glitch_cnt = 0;
  logic        prev_req, prev_ack, prev_we;
  logic [15:0] prev_addr;
  always @(posedge clk) begin
    if (reset) begin
      prev_req <= 1'b0;
    end else begin
      if (mon_has) begin
        obs_mem[obs_wr % 4096] <= mon_ev;
        obs_wr                 <= obs_wr + 1;
      end
      if (int'(spi_reg_write) + int'(spi_reg_read) + int'(mem_req) > 1) ovl_cnt <= ovl_cnt + 1;
      if (prev_req && !prev_ack &&
          (!mem_req || (mem_addr != prev_addr) || (mem_we != prev_we)))
        glitch_cnt <= glitch_cnt + 1;
      prev_req  <= mem_req;
      prev_ack  <= mem_ack;
      prev_we   <= mem_we;
      prev_addr <= mem_addr;
    end
  end

  logic [31:0] exp_q[$];
  int          obs_rd;
  int          wr_seen;

  function automatic logic [31:0] ev_spw(input logic [1:0] s, input logic [2:0] a,
                                         input logic [7:0] d);
    return {4'd1, 2'b00, s, 13'd0, a, d};
  endfunction
  function automatic logic [31:0] ev_spr(input logic [2:0] a);
    return {4'd2, 4'd0, 13'd0, a, 8'd0};
  endfunction
  function automatic logic [31:0] ev_mrd(input logic [15:0] a);
    return {4'd3, 4'd0, a, 8'd0};
  endfunction
  function automatic logic [31:0] ev_mwr(input logic [15:0] a, input logic [7:0] d);
    return {4'd4, 4'd0, a, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Pop every observed event and match it against the scoreboard head
  task automatic service();
    logic [31:0] ev, want;
    while (obs_rd != obs_wr) begin
      ev = obs_mem[obs_rd % 4096];
      obs_rd++;
      if (ev[31:28] == 4'd1) wr_seen++;
      if (exp_q.size() > 0) want = exp_q.pop_front();
      else want = 32'hFFFF_FFFF;
      chk("event", ev, want);
    end
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr  = a;
    host_wdata = d;
    host_write = 1'b1;
    @(negedge clk);
    host_write = 1'b0;
  endtask

  task automatic host_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    host_read = 1'b1;
    #1 d = host_rdata;
    @(negedge clk);
    host_read = 1'b0;
  endtask

  task automatic clr_idx(input logic [7:0] base);
    rx_base = base;
    @(negedge clk);
    idx_clr = 1'b1;
    @(negedge clk);
    idx_clr = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] len, input logic [15:0] tx, input logic [15:0] rx,
                            input logic [7:0] ctrl);
    host_wr(3'd1, len);
    host_wr(3'd2, tx[7:0]);
    host_wr(3'd3, tx[15:8]);
    host_wr(3'd4, rx[7:0]);
    host_wr(3'd5, rx[15:8]);
    wr_seen = 0;
    host_wr(3'd0, ctrl);
  endtask

  task automatic run_until_irq(input int budget, input int abort_at);
    bit got, sent;
    got  = 1'b0;
    sent = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      host_write = 1'b0;
      service();
      if (abort_at > 0 && !sent && wr_seen >= abort_at) begin
        host_addr  = 3'd0;
        host_wdata = 8'h02;
        host_write = 1'b1;
        sent       = 1'b1;
      end
      if (irq === 1'b1) got = 1'b1;
    end
    host_write = 1'b0;
    chk("irq_seen", {31'd0, got}, 32'd1);
    service();
    chk("exp_drained", exp_q.size(), 32'd0);
  endtask

  logic [7:0] rd;
  logic [15:0] a;

  initial begin
    n_tests = 0; n_fail = 0; obs_rd = 0; wr_seen = 0;
    reset = 1'b1; host_addr = 3'd0; host_wdata = 8'd0; host_write = 1'b0; host_read = 1'b0;
    idx_clr = 1'b0; mem_delay = 0; irq_delay = 3; rx_base = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_strobes", {29'd0, mem_req, spi_reg_write, spi_reg_read}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    host_rd(3'd6, rd); chk("rst_status", {24'd0, rd}, 32'h00);
    host_rd(3'd0, rd); chk("rst_ctrl", {24'd0, rd}, 32'h00);
    host_rd(3'd1, rd); chk("rst_len", {24'd0, rd}, 32'h00);
    host_rd(3'd5, rd); chk("rst_rxhi", {24'd0, rd}, 32'h00);

    // 1: single byte, tx+rx, sel 1
    clr_idx(8'h3C);
    exp_q.push_back(ev_mrd(16'h0100));
    exp_q.push_back(ev_spw(2'd1, 3'd0, 8'hA5));
    exp_q.push_back(ev_spr(3'd0));
    exp_q.push_back(ev_mwr(16'h0200, 8'h3C));
    start_xfer(8'd1, 16'h0100, 16'h0200, 8'h35);
    run_until_irq(200, 0);
    chk("t1_irq_high", {31'd0, irq}, 32'd1);
    host_rd(3'd0, rd); chk("t1_ctrl", {24'd0, rd}, 32'h34);
    host_rd(3'd6, rd); chk("t1_status", {24'd0, rd}, 32'h02);
    chk("t1_irq_cleared", {31'd0, irq}, 32'd0);
    host_rd(3'd6, rd); chk("t1_status_clr", {24'd0, rd}, 32'h00);
    host_rd(3'd7, rd); chk("t1_reg7", {24'd0, rd}, 32'h00);

    // 2: 256 bytes, rx only, rx pointer wraps through 0xFFFF
    clr_idx(8'h10);
    for (int i = 0; i < 256; i++) begin
      a = 16'hFF80 + 16'(i);
      exp_q.push_back(ev_spw(2'd2, (i == 0) ? 3'd0 : 3'd1, 8'hFF));
      exp_q.push_back(ev_spr((i == 255) ? 3'd0 : 3'd1));
      exp_q.push_back(ev_mwr(a, 8'h10 + 8'(i)));
    end
    start_xfer(8'd0, 16'h0000, 16'hFF80, 8'h29);
    run_until_irq(20000, 0);
    host_rd(3'd6, rd); chk("t2_status", {24'd0, rd}, 32'h02);

    // 3: three bytes, tx only, tx pointer wraps
    clr_idx(8'h50);
    for (int i = 0; i < 3; i++) begin
      a = 16'hFFFF + 16'(i);
      exp_q.push_back(ev_mrd(a));
      exp_q.push_back(ev_spw(2'd0, (i == 0) ? 3'd0 : 3'd1, tx_byte(a)));
      exp_q.push_back(ev_spr((i == 2) ? 3'd0 : 3'd1));
    end
    start_xfer(8'd3, 16'hFFFF, 16'h0700, 8'h11);
    run_until_irq(500, 0);
    host_rd(3'd6, rd); chk("t3_status", {24'd0, rd}, 32'h02);

    // 4: abort during byte 2 of 10
    irq_delay = 20;
    clr_idx(8'h80);
    for (int i = 0; i < 2; i++) begin
      a = 16'h0300 + 16'(i);
      exp_q.push_back(ev_mrd(a));
      exp_q.push_back(ev_spw(2'd0, (i == 0) ? 3'd0 : 3'd1, tx_byte(a)));
      exp_q.push_back(ev_spr((i == 1) ? 3'd0 : 3'd1));
      exp_q.push_back(ev_mwr(16'h0400 + 16'(i), 8'h80 + 8'(i)));
    end
    start_xfer(8'd10, 16'h0300, 16'h0400, 8'h31);
    run_until_irq(2000, 2);
    host_rd(3'd6, rd); chk("t4_status", {24'd0, rd}, 32'h06);
    repeat (30) @(negedge clk);
    service();
    chk("t4_quiet", {31'd0, mem_req}, 32'd0);
    host_rd(3'd6, rd); chk("t4_status_clr", {24'd0, rd}, 32'h00);

    // 5: slow memory and slow controller; start+abort together in IDLE
    mem_delay = 5;
    irq_delay = 40;
    clr_idx(8'hC0);
    for (int i = 0; i < 2; i++) begin
      a = 16'h0800 + 16'(i);
      exp_q.push_back(ev_mrd(a));
      exp_q.push_back(ev_spw(2'd0, (i == 0) ? 3'd0 : 3'd1, tx_byte(a)));
      exp_q.push_back(ev_spr((i == 1) ? 3'd0 : 3'd1));
      exp_q.push_back(ev_mwr(16'h0900 + 16'(i), 8'hC0 + 8'(i)));
    end
    start_xfer(8'd2, 16'h0800, 16'h0900, 8'h33);
    host_rd(3'd6, rd); chk("t5_busy", {24'd0, rd}, 32'h01);
    run_until_irq(2000, 0);
    host_rd(3'd6, rd); chk("t5_status", {24'd0, rd}, 32'h02);
    chk("t5_req_stable", glitch_cnt, 32'd0);

    // 6: reset while waiting on the controller, then a clean restart
    mem_delay = 0;
    irq_delay = 30;
    clr_idx(8'h00);
    exp_q.push_back(ev_mrd(16'h0A00));
    exp_q.push_back(ev_spw(2'd1, 3'd0, tx_byte(16'h0A00)));
    start_xfer(8'd4, 16'h0A00, 16'h0B00, 8'h35);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk);
        service();
        if (wr_seen >= 1) seen = 1'b1;
      end
      chk("t6_first_write", {31'd0, seen}, 32'd1);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_strobes", {29'd0, mem_req, spi_reg_write, spi_reg_read}, 32'd0);
    host_rd(3'd6, rd); chk("t6_status", {24'd0, rd}, 32'h00);
    chk("t6_irq", {31'd0, irq}, 32'd0);
    repeat (50) @(negedge clk);
    service();
    chk("t6_no_close", exp_q.size(), 32'd0);
    host_rd(3'd1, rd); chk("t6_len_reset", {24'd0, rd}, 32'h00);

    irq_delay = 4;
    clr_idx(8'h20);
    for (int i = 0; i < 2; i++) begin
      a = 16'h0B00 + 16'(i);
      exp_q.push_back(ev_mrd(a));
      exp_q.push_back(ev_spw(2'd3, (i == 0) ? 3'd0 : 3'd1, tx_byte(a)));
      exp_q.push_back(ev_spr((i == 1) ? 3'd0 : 3'd1));
      exp_q.push_back(ev_mwr(16'h0C00 + 16'(i), 8'h20 + 8'(i)));
    end
    start_xfer(8'd2, 16'h0B00, 16'h0C00, 8'h3D);
    host_wr(3'd1, 8'd7);
    host_wr(3'd0, 8'h31);
    run_until_irq(1000, 0);
    host_rd(3'd1, rd); chk("t6_len_kept", {24'd0, rd}, 32'h02);
    host_rd(3'd0, rd); chk("t6_ctrl_kept", {24'd0, rd}, 32'h3C);
    host_rd(3'd6, rd); chk("t6_status_done", {24'd0, rd}, 32'h02);

    chk("no_overlap", ovl_cnt, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
